// File: rtl/card_shoe.sv
// card_shoe: single 52-card deck dealt without replacement.
// A draw starts at a pseudo-random index taken from a 6-bit LFSR. From there
// it walks the dealt mask until it finds an undealt card, and returns that
// card's rank (1..13).
// Ports:
//   slow_clock  - sole clock, rising edge
//   resetb      - asynchronous active-low reset
//   draw_req    - request one card (honoured only when idle)
//   shuffle     - return all cards to the shoe; aborts any draw in progress
//   new_card    - rank of the most recently dealt card, 0 after reset/shuffle
//   card_valid  - one-cycle pulse when new_card has just been updated
//   busy        - a draw is in progress
//   cards_left  - undealt cards remaining, 0..52
//   shoe_empty  - cards_left == 0
//   draw_err    - one-cycle pulse for a draw request on an empty shoe
module card_shoe #(
  parameter logic [5:0] SEED = 6'b000001
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       draw_req,
  input  logic       shuffle,
  output logic [3:0] new_card,
  output logic       card_valid,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       shoe_empty,
  output logic       draw_err
);

  typedef enum logic [1:0] {IDLE, SEARCH, DEAL} state_t;

  state_t      state, state_next;
  logic [51:0] mask;
  logic [5:0]  ptr;
  logic [5:0]  lfsr;
  logic [5:0]  start;
  logic [3:0]  rank;

  // Fold the LFSR value (1..63) into the deck range 0..51.
  always_comb start = (lfsr < 6'd52) ? lfsr : lfsr - 6'd52;

  // Rank = (ptr mod 13) + 1 with ptr in 0..51.
  always_comb begin
    if (ptr >= 6'd39)      rank = 4'(ptr - 6'd38);
    else if (ptr >= 6'd26) rank = 4'(ptr - 6'd25);
    else if (ptr >= 6'd13) rank = 4'(ptr - 6'd12);
    else                   rank = 4'(ptr + 6'd1);
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (!shuffle && draw_req && cards_left != 6'd0) state_next = SEARCH;
      SEARCH:  if (shuffle) state_next = IDLE;
               else if (!mask[ptr]) state_next = DEAL;
      DEAL:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb shoe_empty = (cards_left == 6'd0);

  // The free card located in SEARCH is committed on the edge that leaves
  // DEAL. This way new_card, cards_left/shoe_empty and the registered
  // card_valid pulse all change together, and a shuffle during DEAL leaves
  // the deck untouched with no pulse.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      mask       <= '0;
      ptr        <= '0;
      lfsr       <= SEED;
      cards_left <= 6'd52;
      new_card   <= '0;
      card_valid <= 1'b0;
      draw_err   <= 1'b0;
    end else begin
      lfsr       <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
      card_valid <= 1'b0;
      draw_err   <= 1'b0;
      if (shuffle) begin
        mask       <= '0;
        cards_left <= 6'd52;
        new_card   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (draw_req) begin
              if (cards_left == 6'd0) draw_err <= 1'b1;
              else                    ptr      <= start;
            end
          end
          SEARCH: begin
            if (mask[ptr]) ptr <= (ptr == 6'd51) ? 6'd0 : ptr + 6'd1;
          end
          DEAL: begin
            mask[ptr]  <= 1'b1;
            if (cards_left != 6'd0) cards_left <= cards_left - 6'd1;
            new_card   <= rank;
            card_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: directed bench for card_shoe.
// A reference LFSR and deck model predict the rank and latency of each draw.
// Each prediction is queued as the draw is issued and compared when
// card_valid appears.
module tb_card_shoe;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic       draw_req   = 1'b0;
  logic       shuffle    = 1'b0;
  logic [3:0] new_card;
  logic       card_valid;
  logic       busy;
  logic [5:0] cards_left;
  logic       shoe_empty;
  logic       draw_err;

  always #5 slow_clock = ~slow_clock;

  card_shoe #(.SEED(6'b000001)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .draw_req   (draw_req),
    .shuffle    (shuffle),
    .new_card   (new_card),
    .card_valid (card_valid),
    .busy       (busy),
    .cards_left (cards_left),
    .shoe_empty (shoe_empty),
    .draw_err   (draw_err)
  );

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [5:0] m_lfsr;
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) m_lfsr <= 6'b000001;
    else         m_lfsr <= {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
  end

  always @(negedge slow_clock) if (card_valid === 1'b1) pulses++;

  typedef struct {int rank; int lat;} exp_t;
  exp_t sb[$];
  bit   m_mask[52];
  int   m_left;
  int   hist[14];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge slow_clock);
    #1;
  endtask

  task automatic model_clear();
    foreach (m_mask[i]) m_mask[i] = 1'b0;
    m_left = 52;
  endtask

  // Called just before the edge that samples draw_req.
  task automatic model_push();
    int p;
    int n;
    exp_t e;
    p = (m_lfsr < 6'd52) ? int'(m_lfsr) : int'(m_lfsr) - 52;
    n = 0;
    while (m_mask[p]) begin
      n++;
      p = (p == 51) ? 0 : p + 1;
    end
    m_mask[p] = 1'b1;
    m_left--;
    e.rank = (p % 13) + 1;
    e.lat  = 3 + n;
    sb.push_back(e);
  endtask

  task automatic draw();
    exp_t e;
    int   c;
    model_push();
    draw_req = 1'b1;
    cyc();
    draw_req = 1'b0;
    c = 1;
    while (card_valid !== 1'b1 && c < 60) begin
      cyc();
      c++;
    end
    e = sb.pop_front();
    check("card_valid", card_valid, 1);
    check("latency", c, e.lat);
    check("new_card", new_card, e.rank);
    check("cards_left", cards_left, m_left);
    check("shoe_empty", shoe_empty, (m_left == 0) ? 1 : 0);
    check("busy_after_deal", busy, 0);
    if (new_card <= 4'd13) hist[new_card]++;
    cyc();
    check("valid_width", card_valid, 0);
  endtask

  task automatic check_hist();
    for (int r = 1; r <= 13; r++) begin
      check($sformatf("rank%0d_count", r), hist[r], 4);
      hist[r] = 0;
    end
  endtask

  initial begin
    int p0;
    foreach (hist[i]) hist[i] = 0;
    model_clear();

    // Reset state and idle behaviour.
    repeat (3) cyc();
    resetb = 1'b1;
    cyc();
    check("rst_cards_left", cards_left, 52);
    check("rst_shoe_empty", shoe_empty, 0);
    check("rst_new_card", new_card, 0);
    check("rst_busy", busy, 0);
    check("rst_draw_err", draw_err, 0);
    repeat (5) cyc();
    check("rst_no_pulses", pulses, 0);

    // Deal the whole shoe.
    for (int i = 0; i < 52; i++) draw();
    check_hist();
    check("full_deal_pulses", pulses, 52);

    // Draw from an empty shoe.
    p0 = pulses;
    draw_req = 1'b1;
    cyc();
    draw_req = 1'b0;
    check("empty_draw_err", draw_err, 1);
    check("empty_busy", busy, 0);
    cyc();
    check("empty_err_width", draw_err, 0);
    check("empty_busy2", busy, 0);
    repeat (4) cyc();
    check("empty_cards_left", cards_left, 0);
    check("empty_no_valid", pulses, p0);

    // Shuffle in IDLE.
    shuffle = 1'b1;
    cyc();
    shuffle = 1'b0;
    model_clear();
    check("shuf_cards_left", cards_left, 52);
    check("shuf_new_card", new_card, 0);
    check("shuf_shoe_empty", shoe_empty, 0);

    // Shuffle aborting a draw in SEARCH.
    for (int i = 0; i < 3; i++) draw();
    p0 = pulses;
    draw_req = 1'b1;
    cyc();
    draw_req = 1'b0;
    check("abort_busy_search", busy, 1);
    shuffle = 1'b1;
    cyc();
    shuffle = 1'b0;
    model_clear();
    check("abort_busy", busy, 0);
    check("abort_cards_left", cards_left, 52);
    check("abort_new_card", new_card, 0);
    repeat (5) cyc();
    check("abort_no_valid", pulses, p0);

    // draw_req and shuffle together with 10 cards left.
    for (int i = 0; i < 42; i++) draw();
    check("ten_left", cards_left, 10);
    p0 = pulses;
    draw_req = 1'b1;
    shuffle  = 1'b1;
    cyc();
    draw_req = 1'b0;
    shuffle  = 1'b0;
    model_clear();
    check("both_cards_left", cards_left, 52);
    check("both_busy", busy, 0);
    check("both_new_card", new_card, 0);
    repeat (5) cyc();
    check("both_busy_later", busy, 0);
    check("both_no_valid", pulses, p0);

    // Asynchronous reset in the middle of a search.
    for (int i = 0; i < 20; i++) draw();
    check("pre_reset_left", cards_left, 32);
    p0 = pulses;
    draw_req = 1'b1;
    cyc();
    draw_req = 1'b0;
    check("mid_busy", busy, 1);
    resetb = 1'b0;
    #1;
    check("mid_rst_cards_left", cards_left, 52);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_new_card", new_card, 0);
    check("mid_rst_shoe_empty", shoe_empty, 0);
    model_clear();
    foreach (hist[i]) hist[i] = 0;
    cyc();
    resetb = 1'b1;
    cyc();
    check("mid_rst_no_valid", pulses, p0);
    for (int i = 0; i < 52; i++) draw();
    check_hist();
    check("redeal_empty", shoe_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
